// File: rtl/tls_pkg.sv
// Shared types and constants for the traffic-light command path.
// Defaults here are the power-up durations the sequencer expects.
package tls_pkg;

    localparam int TLS_DW = 4;

    localparam logic [TLS_DW-1:0] TLS_DEF_G = 4'd5;
    localparam logic [TLS_DW-1:0] TLS_DEF_Y = 4'd2;
    localparam logic [TLS_DW-1:0] TLS_DEF_R = 4'd4;

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        SETP
    } cfg_state_t;

endpackage

// File: rtl/tls_debounce.sv
// 2-flop synchroniser plus run-length debouncer.
// Ports: clk, reset, din (raw) -> level (debounced), rise (1-cycle 0->1 pulse).
module tls_debounce #(
    parameter int DEB_CYC = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise
);

    localparam int CW = $clog2(DEB_CYC + 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;

    // The level flips on the DEB_CYC-th consecutive differing sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            level <= 1'b0;
            rise  <= 1'b0;
            cnt   <= '0;
        end else begin
            s1   <= din;
            s2   <= s1;
            rise <= 1'b0;
            if (s2 != level) begin
                if (cnt == CW'(DEB_CYC - 1)) begin
                    level <= s2;
                    rise  <= s2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/tls_cmd_gen.sv
// Command generator feeding the traffic-light sequencer.
// Ports: cfg_* handshake in, ped_btn/emg raw in, Gout/Yout/Rout feedback in;
// Set/Stop/Jump/Gin/Yin/Rin to sequencer, cfg_ready/cfg_err/ped_pending status.
module tls_cmd_gen
    import tls_pkg::*;
#(
    parameter logic [TLS_DW-1:0] DEF_G     = TLS_DEF_G,
    parameter logic [TLS_DW-1:0] DEF_Y     = TLS_DEF_Y,
    parameter logic [TLS_DW-1:0] DEF_R     = TLS_DEF_R,
    parameter int                DEB_CYC   = 4,
    parameter int                MIN_GREEN = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [TLS_DW-1:0] cfg_g,
    input  logic [TLS_DW-1:0] cfg_y,
    input  logic [TLS_DW-1:0] cfg_r,
    output logic              cfg_err,
    input  logic              ped_btn,
    input  logic              emg,
    input  logic              Gout,
    input  logic              Yout,
    input  logic              Rout,
    output logic              Set,
    output logic              Stop,
    output logic              Jump,
    output logic [TLS_DW-1:0] Gin,
    output logic [TLS_DW-1:0] Yin,
    output logic [TLS_DW-1:0] Rin,
    output logic              ped_pending
);

    localparam int GTW = $clog2(MIN_GREEN + 1);

    cfg_state_t        state;
    cfg_state_t        nxt;
    logic              accept;
    logic              cfg_ok;
    logic              set_nxt;
    logic              err_nxt;
    logic [TLS_DW-1:0] g_nxt;
    logic [TLS_DW-1:0] y_nxt;
    logic [TLS_DW-1:0] r_nxt;

    logic              emg_s1;
    logic              ped_lvl;
    logic              ped_rise;
    logic [GTW-1:0]    gt;
    logic [GTW-1:0]    gt_nxt;
    logic              jump_nxt;
    logic              rout_clr;
    logic              pend_nxt;

    // Yellow feedback and the debounced level carry no decisions here.
    logic unused_fb;
    assign unused_fb = ^{Yout, ped_lvl};

    assign accept = cfg_valid & cfg_ready;
    assign cfg_ok = (|cfg_g) & (|cfg_y) & (|cfg_r);

    // Config FSM: state register.
    always_ff @(posedge clk) begin
        if (reset) state <= INIT;
        else       state <= nxt;
    end

    // Config FSM: next state.
    always_comb begin
        nxt = state;
        unique case (state)
            INIT:    nxt = IDLE;
            IDLE:    if (accept && cfg_ok) nxt = SETP;
            SETP:    nxt = IDLE;
            default: nxt = INIT;
        endcase
    end

    // Config FSM: outputs (next values of registered outputs).
    always_comb begin
        set_nxt = 1'b0;
        err_nxt = 1'b0;
        g_nxt   = Gin;
        y_nxt   = Yin;
        r_nxt   = Rin;
        unique case (state)
            INIT: begin
                set_nxt = 1'b1;
                g_nxt   = DEF_G;
                y_nxt   = DEF_Y;
                r_nxt   = DEF_R;
            end
            IDLE: begin
                if (accept) begin
                    if (cfg_ok) begin
                        set_nxt = 1'b1;
                        g_nxt   = cfg_g;
                        y_nxt   = cfg_y;
                        r_nxt   = cfg_r;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    tls_debounce #(
        .DEB_CYC (DEB_CYC)
    ) u_ped (
        .clk   (clk),
        .reset (reset),
        .din   (ped_btn),
        .level (ped_lvl),
        .rise  (ped_rise)
    );

    // Green timer restarts whenever a Set goes out, so a fresh load
    // always gets a full minimum green before a Jump.
    always_comb begin
        if (!Gout || set_nxt)
            gt_nxt = '0;
        else if (gt >= GTW'(MIN_GREEN))
            gt_nxt = gt;
        else
            gt_nxt = gt + GTW'(1);
    end

    assign jump_nxt = ped_pending & Gout & (gt >= GTW'(MIN_GREEN))
                    & ~Stop & ~set_nxt & ~Jump;
    // A red already showing satisfies the request; held while stopped.
    assign rout_clr = ped_pending & Rout & ~Stop;
    // New press beats any clear on the same edge.
    assign pend_nxt = ped_rise | (ped_pending & ~jump_nxt & ~rout_clr);

    always_ff @(posedge clk) begin
        if (reset) begin
            Set         <= 1'b0;
            cfg_err     <= 1'b0;
            cfg_ready   <= 1'b0;
            Gin         <= DEF_G;
            Yin         <= DEF_Y;
            Rin         <= DEF_R;
            emg_s1      <= 1'b0;
            Stop        <= 1'b0;
            gt          <= '0;
            Jump        <= 1'b0;
            ped_pending <= 1'b0;
        end else begin
            Set         <= set_nxt;
            cfg_err     <= err_nxt;
            cfg_ready   <= (nxt == IDLE);
            Gin         <= g_nxt;
            Yin         <= y_nxt;
            Rin         <= r_nxt;
            emg_s1      <= emg;
            Stop        <= emg_s1;
            gt          <= gt_nxt;
            Jump        <= jump_nxt;
            ped_pending <= pend_nxt;
        end
    end

endmodule

// File: tb/tb_tls_cmd_gen.sv
// Directed scoreboard bench for tls_cmd_gen.
// Expected values are queued with a due cycle and checked when that cycle arrives.
module tb_tls_cmd_gen;

    localparam int DEB = 4;
    localparam int PED_LAT = 3 + DEB;

    logic       clk = 1'b0;
    logic       reset;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [3:0] cfg_g;
    logic [3:0] cfg_y;
    logic [3:0] cfg_r;
    logic       cfg_err;
    logic       ped_btn;
    logic       emg;
    logic       Gout;
    logic       Yout;
    logic       Rout;
    logic       Set;
    logic       Stop;
    logic       Jump;
    logic [3:0] Gin;
    logic [3:0] Yin;
    logic [3:0] Rin;
    logic       ped_pending;

    tls_cmd_gen #(
        .DEB_CYC   (DEB),
        .MIN_GREEN (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_g       (cfg_g),
        .cfg_y       (cfg_y),
        .cfg_r       (cfg_r),
        .cfg_err     (cfg_err),
        .ped_btn     (ped_btn),
        .emg         (emg),
        .Gout        (Gout),
        .Yout        (Yout),
        .Rout        (Rout),
        .Set         (Set),
        .Stop        (Stop),
        .Jump        (Jump),
        .Gin         (Gin),
        .Yin         (Yin),
        .Rin         (Rin),
        .ped_pending (ped_pending)
    );

    always #5 clk = ~clk;

    typedef enum int {S_SET, S_STOP, S_JUMP, S_READY, S_ERR, S_PEND, S_DUR} sel_e;

    typedef struct {
        int          due;
        sel_e        sel;
        logic [11:0] exp;
        string       tag;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   ncomp = 0;
    int   nfail = 0;

    function automatic logic [11:0] obs(sel_e s);
        case (s)
            S_SET:   return {11'd0, Set};
            S_STOP:  return {11'd0, Stop};
            S_JUMP:  return {11'd0, Jump};
            S_READY: return {11'd0, cfg_ready};
            S_ERR:   return {11'd0, cfg_err};
            S_PEND:  return {11'd0, ped_pending};
            default: return {Gin, Yin, Rin};
        endcase
    endfunction

    task automatic push_exp(input int d, input sel_e s,
                            input logic [11:0] v, input string tag);
        exp_t e;
        e.due = cyc + d;
        e.sel = s;
        e.exp = v;
        e.tag = tag;
        q.push_back(e);
    endtask

    task automatic check_due();
        logic [11:0] o;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].due == cyc) begin
                ncomp++;
                o = obs(q[i].sel);
                assert (o === q[i].exp) else begin
                    nfail++;
                    $error("FAIL %s @cyc %0d: observed %0h expected %0h",
                           q[i].tag, cyc, o, q[i].exp);
                end
                q.delete(i);
            end
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            cyc++;
            check_due();
        end
    endtask

    initial begin
        reset     = 1'b1;
        cfg_valid = 1'b0;
        cfg_g     = 4'd0;
        cfg_y     = 4'd0;
        cfg_r     = 4'd0;
        ped_btn   = 1'b0;
        emg       = 1'b0;
        Gout      = 1'b0;
        Yout      = 1'b0;
        Rout      = 1'b0;

        // reset state
        push_exp(1, S_SET, 0, "rst_set");
        push_exp(1, S_READY, 0, "rst_ready");
        push_exp(1, S_DUR, 12'h524, "rst_dur");
        push_exp(1, S_PEND, 0, "rst_pend");
        push_exp(1, S_STOP, 0, "rst_stop");
        push_exp(2, S_JUMP, 0, "rst_jump");
        step(2);

        // power-up Set with defaults
        reset = 1'b0;
        push_exp(1, S_SET, 1, "init_set");
        push_exp(1, S_DUR, 12'h524, "init_dur");
        push_exp(2, S_SET, 0, "init_set_off");
        push_exp(2, S_READY, 1, "init_ready");
        step(2);

        // good config 7/3/6
        cfg_valid = 1'b1;
        cfg_g = 4'd7; cfg_y = 4'd3; cfg_r = 4'd6;
        push_exp(1, S_SET, 1, "cfg_set");
        push_exp(1, S_DUR, 12'h736, "cfg_dur");
        push_exp(1, S_READY, 0, "cfg_setp_busy");
        push_exp(2, S_READY, 1, "cfg_ready_back");
        push_exp(2, S_SET, 0, "cfg_set_off");
        step(1);
        cfg_valid = 1'b0;
        step(1);

        // rejected config (g=0)
        cfg_valid = 1'b1;
        cfg_g = 4'd0; cfg_y = 4'd1; cfg_r = 4'd1;
        push_exp(1, S_ERR, 1, "bad_err");
        push_exp(1, S_SET, 0, "bad_noset");
        push_exp(1, S_DUR, 12'h736, "bad_dur_kept");
        push_exp(1, S_READY, 1, "bad_ready");
        push_exp(2, S_ERR, 0, "bad_err_off");
        step(1);
        cfg_valid = 1'b0;
        step(1);

        // short 2-cycle glitch: filtered
        for (int i = 1; i <= 8; i++) push_exp(i, S_PEND, 0, "short_pend");
        ped_btn = 1'b1;
        step(2);
        ped_btn = 1'b0;
        step(6);

        // long press: pending exactly after sync + DEB samples + 1
        for (int i = 1; i < PED_LAT; i++) push_exp(i, S_PEND, 0, "long_pre");
        push_exp(PED_LAT, S_PEND, 1, "long_pend");
        for (int i = 1; i <= 18; i++) push_exp(i, S_JUMP, 0, "long_nojump");
        push_exp(18, S_PEND, 1, "long_held");
        ped_btn = 1'b1;
        step(10);
        ped_btn = 1'b0;
        step(8);

        // Jump after minimum green
        Gout = 1'b1;
        for (int i = 1; i <= 3; i++) push_exp(i, S_JUMP, 0, "mg_wait");
        push_exp(3, S_PEND, 1, "mg_pend");
        push_exp(4, S_JUMP, 1, "mg_jump");
        push_exp(4, S_PEND, 0, "mg_pend_clr");
        push_exp(5, S_JUMP, 0, "mg_jump_once");
        push_exp(6, S_JUMP, 0, "mg_jump_once2");
        step(6);
        Gout = 1'b0;

        // Rout clears pending without Jump
        ped_btn = 1'b1;
        push_exp(PED_LAT, S_PEND, 1, "rout_pend");
        step(PED_LAT);
        Rout = 1'b1;
        push_exp(1, S_PEND, 0, "rout_clr");
        for (int i = 1; i <= 3; i++) push_exp(i, S_JUMP, 0, "rout_nojump");
        push_exp(3, S_PEND, 0, "rout_no_retrig");
        step(3);
        Rout = 1'b0;
        ped_btn = 1'b0;
        step(8);

        // emergency hold suppresses Jump, resumes afterwards
        ped_btn = 1'b1;
        push_exp(PED_LAT, S_PEND, 1, "emg_pend");
        step(PED_LAT);
        Gout = 1'b1;
        emg  = 1'b1;
        push_exp(1, S_STOP, 0, "emg_lat1");
        push_exp(2, S_STOP, 1, "emg_stop");
        for (int i = 1; i <= 8; i++) push_exp(i, S_JUMP, 0, "emg_nojump");
        push_exp(8, S_PEND, 1, "emg_held");
        step(8);
        emg = 1'b0;
        push_exp(1, S_STOP, 1, "emg_rel1");
        push_exp(2, S_STOP, 0, "emg_rel");
        push_exp(2, S_JUMP, 0, "emg_rel_nojump");
        push_exp(3, S_JUMP, 1, "emg_jump");
        push_exp(3, S_PEND, 0, "emg_pend_clr");
        push_exp(4, S_JUMP, 0, "emg_jump_once");
        step(5);
        ped_btn = 1'b0;
        Gout = 1'b0;
        step(8);

        // Set beats Jump on the same edge
        ped_btn = 1'b1;
        push_exp(PED_LAT, S_PEND, 1, "svj_pend");
        step(PED_LAT);
        Gout = 1'b1;
        for (int i = 1; i <= 3; i++) push_exp(i, S_JUMP, 0, "svj_green");
        step(3);
        cfg_valid = 1'b1;
        cfg_g = 4'd9; cfg_y = 4'd1; cfg_r = 4'd2;
        push_exp(1, S_SET, 1, "svj_set");
        push_exp(1, S_DUR, 12'h912, "svj_dur");
        for (int i = 1; i <= 4; i++) push_exp(i, S_JUMP, 0, "svj_nojump");
        push_exp(4, S_PEND, 1, "svj_pend_kept");
        push_exp(5, S_JUMP, 1, "svj_jump");
        push_exp(5, S_PEND, 0, "svj_pend_clr");
        push_exp(6, S_JUMP, 0, "svj_jump_once");
        step(1);
        cfg_valid = 1'b0;
        step(5);
        ped_btn = 1'b0;
        Gout = 1'b0;
        step(8);

        // reset during SETP reissues defaults
        cfg_valid = 1'b1;
        cfg_g = 4'd8; cfg_y = 4'd8; cfg_r = 4'd8;
        push_exp(1, S_SET, 1, "rs_set");
        push_exp(1, S_DUR, 12'h888, "rs_dur");
        step(1);
        cfg_valid = 1'b0;
        reset = 1'b1;
        push_exp(1, S_SET, 0, "rs_rst_set");
        push_exp(1, S_DUR, 12'h524, "rs_rst_dur");
        push_exp(1, S_READY, 0, "rs_rst_ready");
        step(1);
        reset = 1'b0;
        push_exp(1, S_SET, 1, "rs_reinit_set");
        push_exp(1, S_DUR, 12'h524, "rs_reinit_dur");
        push_exp(2, S_SET, 0, "rs_set_off");
        push_exp(2, S_READY, 1, "rs_ready");
        step(2);

        step(2);
        ncomp++;
        assert (q.size() == 0) else begin
            nfail++;
            $error("FAIL scoreboard_drain: observed %0d pending expected 0",
                   q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule

// File: doc/tls_cmd_gen.md
Name: tls_cmd_gen

Overview:
Command generator that sits directly upstream of the traffic-light sequencer and drives its Set/Stop/Jump/Gin/Yin/Rin inputs. It accepts duration configuration over a valid/ready handshake and issues the Set pulse. It debounces a raw pedestrian button and converts it into a Jump, respecting a minimum green time, and synchronises an emergency-hold input into Stop. It observes the sequencer's Gout/Yout/Rout as feedback.

Parameters:
DEF_G, 4'd5, green duration loaded at power-up Set
DEF_Y, 4'd2, yellow duration loaded at power-up Set
DEF_R, 4'd4, red duration loaded at power-up Set
DEB_CYC, 4, consecutive stable synchronised samples needed to change debounced button level (>=1)
MIN_GREEN, 3, minimum cycles Gout must be high before a Jump is allowed (>=1)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
cfg_valid  in  1  new duration set offered
cfg_ready  out  1  block can accept config
cfg_g  in  4  green duration
cfg_y  in  4  yellow duration
cfg_r  in  4  red duration
cfg_err  out  1  one-cycle pulse: accepted config rejected (a zero field)
ped_btn  in  1  raw asynchronous pedestrian button
emg  in  1  raw asynchronous emergency hold
Gout  in  1  sequencer green feedback
Yout  in  1  sequencer yellow feedback
Rout  in  1  sequencer red feedback
Set  out  1  one-cycle load pulse to sequencer
Stop  out  1  hold level to sequencer
Jump  out  1  one-cycle jump-to-red pulse
Gin  out  4  green duration, stable except on Set cycles
Yin  out  4  yellow duration
Rin  out  4  red duration
ped_pending  out  1  pedestrian request outstanding

Behaviour:
- One clock, clk. Reset is synchronous and active-high; all outputs are registered.
- Reset values: Set=0, Stop=0, Jump=0, cfg_ready=0, cfg_err=0, ped_pending=0, Gin/Yin/Rin=DEF_G/DEF_Y/DEF_R, all counters and synchronisers 0, config FSM=INIT.
- Config FSM states:
  - INIT: the first cycle after reset deasserts drives Set=1 with the defaults. Next state is IDLE.
  - IDLE: cfg_ready=1. An accept is cfg_valid&cfg_ready at edge t.
    - If cfg_g, cfg_y and cfg_r are all nonzero: Gin/Yin/Rin update at t+1 and Set=1 at t+1. Go to SETP, where cfg_ready=0 for one cycle, then return to IDLE (ready again at t+2).
    - If any field is 0: cfg_err=1 at t+1, registers are unchanged, no Set, stay in IDLE.
  - Reset in any state returns to INIT; a Set is reissued with the defaults, not the last loaded values.
- Stop: emg passes through a 2-flop synchroniser, then Stop = synchronised value. Latency is 2 cycles; no debounce.
- Pedestrian path:
  - ped_btn passes through a 2-flop synchroniser.
  - The debounced level flips only after DEB_CYC consecutive samples differ from it. Any mismatch-free sample resets the run counter.
  - A 0->1 debounced edge sets ped_pending. Holding the button does not retrigger.
- Green timer: counts cycles with Gout=1 and saturates at MIN_GREEN. It clears when Gout=0 or in any cycle where Set is issued.
- Jump is issued (Jump=1 next cycle, ped_pending cleared on the same edge) when all of these hold:
  - ped_pending=1 and Gout=1
  - green timer >= MIN_GREEN
  - Stop=0
  - no Set is being issued that edge
- Pending cleared without Jump: if Rout=1 is observed while pending, clear pending with no Jump (the request is already satisfied).
- Jump is never asserted on two consecutive cycles.
- Priorities:
  - Set beats Jump. If both qualify on the same edge, only Set fires; pending is kept and the green timer restarts.
  - A new debounced press on the same edge as a pending clear: the press wins, so pending=1.
  - While Stop=1, the pending request is held and Jump is suppressed. Jump can resume once Stop drops.
- Config acceptance is independent of Stop.

Decomposition:
- Shared package tls_pkg holds:
  - config FSM enum {INIT, IDLE, SETP}
  - duration width constant TLS_DW=4
  - DEF_G/DEF_Y/DEF_R default constants, so the sequencer and this block agree.
- Sub-module tls_debounce (2-flop sync + DEB_CYC run counter, outputs debounced level and rise pulse). Instantiate once for ped_btn; emg uses only its own synchroniser.

Test Plan:
- Reset held 2 cycles, then released -> Set=1 exactly 1 cycle later with Gin/Yin/Rin=5/2/4; cfg_ready=1 the cycle after.
- cfg_valid with g/y/r=7/3/6 in IDLE -> Set=1 and Gin/Yin/Rin=7/3/6 next cycle, cfg_ready=0 that cycle and 1 the following cycle. A second offer with g=0 -> cfg_err=1 for 1 cycle, no Set, outputs stay 7/3/6.
- ped_btn pulses high 2 cycles (DEB_CYC=4) -> no pending. Held high for 10 cycles -> ped_pending=1 at sync+4 samples, exactly one rise.
- Pending while Gout has been high 1 cycle (MIN_GREEN=3) -> Jump=1 exactly once, when the green timer reaches 3; pending=0 the same edge. With Rout=1 instead -> pending clears, Jump stays 0.
- emg=1 with pending and green satisfied -> Stop=1 after 2 cycles, Jump held 0. emg=0 -> Stop=0 after 2 cycles, then Jump=1 once.
- Config accept on the same edge the Jump condition qualifies -> only Set fires, pending stays 1, Jump issued after MIN_GREEN further green cycles. Reset asserted mid-SETP -> INIT, Set reissued with 5/2/4.
